interrupt_sequencer: RTL and testbench

Sequential owner of the interrupt control/status register (LPC address 0x09). It synchronises and edge-detects power-button, reset-button and watchdog events, and latches them into sticky status bits with write-1-to-clear. It drives a CPU interrupt request with a guaranteed minimum assert time and a re-arm holdoff. It also keeps a saturating count of delivered interrupts. It sits between the LPC register file and the top-level open-drain interrupt pad, which drives low when IntReq=1.

---
 rtl/interrupt_sequencer.sv | 168 ++++++++++++++++
 tb/tb_interrupt_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_sequencer.sv
// Interrupt status/control register owner: synchronises button/watchdog events into sticky W1C bits and drives IntReq.
// Latency: raw input high -> status on the 3rd clock edge; status with enable -> IntReq two edges later.
// Backpressure: none; events are held in sticky status bits until software clears them, and IntReq keeps minimum pulse/gap timing.
module interrupt_sequencer #(
    parameter logic [7:0] INT_ADDR  = 8'h09,
    parameter int         PULSE_MIN = 4,
    parameter int         HOLDOFF   = 2
) (
    input  logic       CLK32768,
    input  logic       PORB,
    input  logic       Wr,
    input  logic [7:0] Addr,
    input  logic [7:0] DataWr,
    input  logic       ATX,
    input  logic [2:0] EnableInt,
    input  logic [3:0] Interrupt,
    input  logic       WatchDogIREQ,
    output logic [2:0] IntStatus,
    output logic       IntReq,
    output logic [7:0] IntCount
);

    localparam logic [3:0] PULSE_MIN_C = PULSE_MIN[3:0];
    localparam logic [3:0] HOLDOFF_C   = HOLDOFF[3:0];

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ASSERT  = 2'd1,
        S_HOLDOFF = 2'd2
    } state_t;

    logic       resetSrc;
    logic       powerSrc;
    logic [1:0] resetSync;
    logic [1:0] powerSync;
    logic       resetPrev;
    logic       powerPrev;
    logic [1:0] armCnt;
    logic       edgeEn;
    logic       resetEdge;
    logic       powerEdge;
    logic       wrClr;
    logic [2:0] setMask;
    logic [2:0] clrMask;
    logic [2:0] statusQ;
    logic       pendingQ;
    state_t     state;
    state_t     stateNext;
    logic [3:0] timer;
    logic [3:0] timerNext;
    logic       intReqQ;
    logic       intReqNext;
    logic [7:0] countQ;
    logic [7:0] countNext;
    logic       unusedData;

    assign resetSrc = ATX ? Interrupt[0] : Interrupt[1];
    assign powerSrc = ATX ? Interrupt[2] : Interrupt[3];

    // Edge detection stays masked until the synchroniser and previous-value flops
    // have been refilled after reset, so a level already high at release is not an event.
    assign edgeEn    = (armCnt == 2'd3);
    assign resetEdge = edgeEn & resetSync[1] & ~resetPrev;
    assign powerEdge = edgeEn & powerSync[1] & ~powerPrev;

    assign wrClr      = Wr & (Addr == INT_ADDR);
    assign setMask    = {WatchDogIREQ, resetEdge, powerEdge};
    assign clrMask    = wrClr ? DataWr[6:4] : 3'b000;
    assign unusedData = ^DataWr[3:0];

    // Two-flop synchronisers, previous-value flops and the post-reset arming counter.
    always_ff @(posedge CLK32768 or negedge PORB) begin
        if (!PORB) begin
            resetSync <= 2'b00;
            powerSync <= 2'b00;
            resetPrev <= 1'b0;
            powerPrev <= 1'b0;
            armCnt    <= 2'd0;
        end else begin
            resetSync <= {resetSync[0], resetSrc};
            powerSync <= {powerSync[0], powerSrc};
            resetPrev <= resetSync[1];
            powerPrev <= powerSync[1];
            if (armCnt != 2'd3) begin
                armCnt <= armCnt + 2'd1;
            end
        end
    end

    // Sticky status bits (set beats clear) and the registered pending decode.
    always_ff @(posedge CLK32768 or negedge PORB) begin
        if (!PORB) begin
            statusQ  <= 3'b000;
            pendingQ <= 1'b0;
        end else begin
            statusQ  <= (statusQ & ~clrMask) | setMask;
            pendingQ <= |(statusQ & EnableInt);
        end
    end

    // Request FSM state, timer, registered IntReq and delivered-interrupt counter.
    always_ff @(posedge CLK32768 or negedge PORB) begin
        if (!PORB) begin
            state   <= S_IDLE;
            timer   <= 4'd0;
            intReqQ <= 1'b0;
            countQ  <= 8'd0;
        end else begin
            state   <= stateNext;
            timer   <= timerNext;
            intReqQ <= intReqNext;
            countQ  <= countNext;
        end
    end

    // Next-state decode: timer holds the number of cycles already spent in ASSERT/HOLDOFF.
    always_comb begin
        stateNext  = state;
        timerNext  = timer;
        intReqNext = 1'b0;
        countNext  = countQ;
        if (wrClr && DataWr[7]) begin
            countNext = 8'd0;
        end
        case (state)
            S_IDLE: begin
                if (pendingQ) begin
                    stateNext  = S_ASSERT;
                    timerNext  = 4'd1;
                    intReqNext = 1'b1;
                    // A request entering ASSERT in the same cycle as a count clear is still counted.
                    if (wrClr && DataWr[7]) begin
                        countNext = 8'd1;
                    end else if (countQ != 8'hFF) begin
                        countNext = countQ + 8'd1;
                    end
                end
            end
            S_ASSERT: begin
                intReqNext = 1'b1;
                if ((timer >= PULSE_MIN_C) && !pendingQ) begin
                    stateNext  = S_HOLDOFF;
                    timerNext  = 4'd1;
                    intReqNext = 1'b0;
                end else if (timer != 4'hF) begin
                    timerNext = timer + 4'd1;
                end
            end
            S_HOLDOFF: begin
                if (timer >= HOLDOFF_C) begin
                    stateNext = S_IDLE;
                    timerNext = 4'd0;
                end else begin
                    timerNext = timer + 4'd1;
                end
            end
            default: begin
                stateNext = S_IDLE;
                timerNext = 4'd0;
            end
        endcase
    end

    assign IntStatus = statusQ;
    assign IntReq    = intReqQ;
    assign IntCount  = countQ;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: reset, edge sync, W1C, watchdog priority, holdoff re-arm, counter saturation.
// Inputs change and outputs are sampled 1 time unit after each rising clock edge.
// Expected values are hand-derived from the register/FSM behaviour with PULSE_MIN=4, HOLDOFF=2.
module tb_interrupt_sequencer;

    logic       CLK32768 = 1'b0;
    logic       PORB;
    logic       Wr;
    logic [7:0] Addr;
    logic [7:0] DataWr;
    logic       ATX;
    logic [2:0] EnableInt;
    logic [3:0] Interrupt;
    logic       WatchDogIREQ;
    logic [2:0] IntStatus;
    logic       IntReq;
    logic [7:0] IntCount;

    int nAsserts = 0;
    int nFails   = 0;

    interrupt_sequencer #(
        .INT_ADDR (8'h09),
        .PULSE_MIN(4),
        .HOLDOFF  (2)
    ) dut (
        .CLK32768    (CLK32768),
        .PORB        (PORB),
        .Wr          (Wr),
        .Addr        (Addr),
        .DataWr      (DataWr),
        .ATX         (ATX),
        .EnableInt   (EnableInt),
        .Interrupt   (Interrupt),
        .WatchDogIREQ(WatchDogIREQ),
        .IntStatus   (IntStatus),
        .IntReq      (IntReq),
        .IntCount    (IntCount)
    );

    always #5 CLK32768 = ~CLK32768;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK32768);
        #1;
    endtask

    task automatic wrReg(input logic [7:0] a, input logic [7:0] d);
        Wr     = 1'b1;
        Addr   = a;
        DataWr = d;
        tick(1);
        Wr     = 1'b0;
        Addr   = 8'h00;
        DataWr = 8'h00;
    endtask

    initial begin
        PORB         = 1'b0;
        Wr           = 1'b0;
        Addr         = 8'h00;
        DataWr       = 8'h00;
        ATX          = 1'b1;
        EnableInt    = 3'b000;
        Interrupt    = 4'hF;
        WatchDogIREQ = 1'b1;

        // Reset held with every source active
        tick(3);
        check("rst_status", {5'd0, IntStatus}, 8'h00);
        check("rst_req",    {7'd0, IntReq},    8'h00);
        check("rst_count",  IntCount,          8'h00);

        // Release with levels steady high: no edge, no status
        WatchDogIREQ = 1'b0;
        tick(1);
        PORB = 1'b1;
        tick(6);
        check("rel_steady_high", {5'd0, IntStatus}, 8'h00);
        check("rel_req",         {7'd0, IntReq},    8'h00);
        Interrupt = 4'h0;
        tick(4);

        // Power event, ATX=1: status on 3rd edge, IntReq two edges later
        EnableInt = 3'b001;
        Interrupt = 4'b0100;
        tick(2);
        check("pwr_sync_lag", {5'd0, IntStatus}, 8'h00);
        tick(1);
        check("pwr_status", {5'd0, IntStatus}, 8'h01);
        wrReg(8'h09, 8'h10);
        check("pwr_clr",    {5'd0, IntStatus}, 8'h00);
        check("pwr_decode", {7'd0, IntReq},    8'h00);
        tick(1);
        check("pwr_req_rise", {7'd0, IntReq}, 8'h01);
        check("pwr_count",    IntCount,       8'h01);
        Interrupt = 4'h0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("pwr_pulse_hold", {7'd0, IntReq}, 8'h01);
        end
        tick(1);
        check("pwr_pulse_end", {7'd0, IntReq}, 8'h00);
        tick(3);
        check("pwr_stays_low", {7'd0, IntReq}, 8'h00);
        check("pwr_count_hold", IntCount, 8'h01);

        // Source select, ATX=0: Interrupt[0] ignored, Interrupt[1] is the reset source
        ATX       = 1'b0;
        EnableInt = 3'b010;
        Interrupt = 4'b0001;
        tick(4);
        Interrupt = 4'b0000;
        tick(4);
        check("sel_ignored",     {5'd0, IntStatus}, 8'h00);
        check("sel_ignored_req", {7'd0, IntReq},    8'h00);
        Interrupt = 4'b0010;
        tick(3);
        check("sel_status", {5'd0, IntStatus}, 8'h02);
        tick(2);
        check("sel_req",   {7'd0, IntReq}, 8'h01);
        check("sel_count", IntCount,       8'h02);
        Interrupt = 4'b0000;
        wrReg(8'h09, 8'h20);
        tick(3);
        check("sel_req_end", {7'd0, IntReq}, 8'h00);
        tick(3);

        // Watchdog: set beats clear in the same cycle
        EnableInt    = 3'b110;
        WatchDogIREQ = 1'b1;
        wrReg(8'h09, 8'h40);
        check("wd_set_wins", {5'd0, IntStatus}, 8'h04);
        tick(2);
        check("wd_req",   {7'd0, IntReq}, 8'h01);
        check("wd_count", IntCount,       8'h03);
        WatchDogIREQ = 1'b0;
        tick(1);
        check("wd_sticky", {5'd0, IntStatus}, 8'h04);
        // Reset event raised now lands in the first HOLDOFF cycle
        Interrupt = 4'b0010;
        wrReg(8'h09, 8'h40);
        check("wd_clr", {5'd0, IntStatus}, 8'h00);
        tick(1);
        check("wd_min_pulse", {7'd0, IntReq}, 8'h01);
        tick(1);
        check("wd_req_fall",      {7'd0, IntReq},    8'h00);
        check("ho_event_latched", {5'd0, IntStatus}, 8'h02);
        // Gap is HOLDOFF cycles plus the IDLE decode cycle
        tick(1);
        check("ho_gap1", {7'd0, IntReq}, 8'h00);
        tick(1);
        check("ho_gap2", {7'd0, IntReq}, 8'h00);
        tick(1);
        check("ho_rearm",       {7'd0, IntReq}, 8'h01);
        check("ho_rearm_count", IntCount,       8'h04);
        Interrupt = 4'b0000;
        wrReg(8'h09, 8'h20);
        tick(7);

        // Counter saturation via repeated watchdog requests
        EnableInt = 3'b100;
        for (int i = 0; i < 251; i++) begin
            WatchDogIREQ = 1'b1;
            tick(1);
            WatchDogIREQ = 1'b0;
            wrReg(8'h09, 8'h40);
            tick(10);
        end
        check("cnt_reach", IntCount, 8'hFF);
        for (int i = 0; i < 5; i++) begin
            WatchDogIREQ = 1'b1;
            tick(1);
            WatchDogIREQ = 1'b0;
            wrReg(8'h09, 8'h40);
            tick(10);
        end
        check("cnt_sat",      IntCount,       8'hFF);
        check("cnt_idle_req", {7'd0, IntReq}, 8'h00);

        // Count clear leaves status untouched; other addresses are ignored
        EnableInt = 3'b000;
        Interrupt = 4'b0010;
        tick(4);
        Interrupt = 4'b0000;
        check("cnt_pre_status", {5'd0, IntStatus}, 8'h02);
        wrReg(8'h09, 8'h80);
        check("cnt_clr",              IntCount,          8'h00);
        check("cnt_clr_keeps_status", {5'd0, IntStatus}, 8'h02);
        wrReg(8'h08, 8'hFF);
        check("wrong_addr_status", {5'd0, IntStatus}, 8'h02);
        check("wrong_addr_count",  IntCount,          8'h00);

        // Asynchronous reset in the middle of ASSERT
        EnableInt = 3'b010;
        tick(2);
        check("pre_arst_req",   {7'd0, IntReq}, 8'h01);
        check("pre_arst_count", IntCount,       8'h01);
        #2;
        PORB = 1'b0;
        #1;
        check("arst_req",    {7'd0, IntReq},    8'h00);
        check("arst_status", {5'd0, IntStatus}, 8'h00);
        check("arst_count",  IntCount,          8'h00);
        tick(1);
        PORB = 1'b1;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
